// File: rtl/phase_sequencer_if.sv
// Handshake bundle between control_logic (master) and the phase sequencer (slave).
// insn_count width must match the sequencer's CNT_W.
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       nstate;
  logic [2:0]       op;
  logic             rd;
  logic             wr;
  logic             mem_rdy;
  logic             run;
  logic             step;
  logic [2:0]       pstate;
  logic             advance;
  logic             insn_done;
  logic             halted;
  logic             bus_err;
  logic [CNT_W-1:0] insn_count;

  modport master (
    output nstate, op, rd, wr, mem_rdy, run, step,
    input  pstate, advance, insn_done, halted, bus_err, insn_count
  );

  modport slave (
    input  nstate, op, rd, wr, mem_rdy, run, step,
    output pstate, advance, insn_done, halted, bus_err, insn_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// Present-phase register plus run/step/halt controller for the MCU instruction
// cycle; stalls on memory wait states and traps to a bus error on timeout.
module phase_sequencer #(
  parameter logic [2:0] HLT_OP   = 3'b000,
  parameter int         WAIT_MAX = 8,
  parameter int         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  phase_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    MODE_IDLE,
    MODE_RUN,
    MODE_STEP,
    MODE_HALT,
    MODE_ERR
  } mode_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  mode_t            mode_reg, mode_next;
  logic [2:0]       pstate_reg;
  logic             insn_done_reg;
  logic             halted_reg;
  logic             bus_err_reg;
  logic [CNT_W-1:0] insn_count_reg;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;

  logic stall, active, advance, boundary, halt_hit, timeout;

  always_comb begin
    stall     = (bus.rd | bus.wr) & ~bus.mem_rdy;
    active    = (mode_reg == MODE_RUN) || (mode_reg == MODE_STEP);
    advance   = active & ~stall;
    boundary  = advance & (bus.nstate == 3'd0);
    halt_hit  = boundary & (bus.op == HLT_OP);
    timeout   = active & stall & (wait_cnt_reg == WAIT_LAST);
    mode_next = mode_reg;

    // Wait counter saturates rather than wrapping so a long stall can never alias.
    if (active && stall) begin
      wait_cnt_next = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : wait_cnt_reg + 8'd1;
    end else begin
      wait_cnt_next = 8'd0;
    end

    case (mode_reg)
      MODE_IDLE: begin
        if (bus.run) begin
          mode_next = MODE_RUN;
        end else if (bus.step) begin
          mode_next = MODE_STEP;
        end
      end
      MODE_RUN: begin
        if (timeout) begin
          mode_next = MODE_ERR;
        end else if (halt_hit) begin
          mode_next = MODE_HALT;
        end else if (boundary && !bus.run) begin
          mode_next = MODE_IDLE;
        end
      end
      MODE_STEP: begin
        if (timeout) begin
          mode_next = MODE_ERR;
        end else if (halt_hit) begin
          mode_next = MODE_HALT;
        end else if (boundary) begin
          mode_next = MODE_IDLE;
        end
      end
      MODE_HALT: mode_next = MODE_HALT;
      MODE_ERR:  mode_next = MODE_ERR;
      default:   mode_next = MODE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg       <= MODE_IDLE;
      pstate_reg     <= 3'd0;
      insn_done_reg  <= 1'b0;
      halted_reg     <= 1'b0;
      bus_err_reg    <= 1'b0;
      insn_count_reg <= '0;
      wait_cnt_reg   <= 8'd0;
    end else begin
      mode_reg      <= mode_next;
      wait_cnt_reg  <= wait_cnt_next;
      insn_done_reg <= boundary;
      if (advance) begin
        pstate_reg <= bus.nstate;
      end
      if (boundary) begin
        insn_count_reg <= insn_count_reg + CNT_W'(1);
      end
      if (halt_hit) begin
        halted_reg <= 1'b1;
      end
      if (timeout) begin
        bus_err_reg <= 1'b1;
      end
    end
  end

  assign bus.pstate     = pstate_reg;
  assign bus.advance    = advance;
  assign bus.insn_done  = insn_done_reg;
  assign bus.halted     = halted_reg;
  assign bus.bus_err    = bus_err_reg;
  assign bus.insn_count = insn_count_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: driver queues per-cycle expectations and
// retirement events; an independent monitor pops and compares them.
module tb_phase_sequencer;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] OPN = 3'b101;

  typedef struct {
    logic        adv;
    logic [2:0]  ps;
    logic        done;
    logic        halt;
    logic        err;
    logic [15:0] cnt;
  } rec_t;

  typedef struct {
    logic [15:0] cnt;
    logic        halt;
  } ret_t;

  logic clk;
  logic rst;
  logic wr_drv;
  logic [15:0] exp_cnt;
  int checks;
  int errors;
  rec_t rec_q[$];
  ret_t ret_q[$];

  phase_sequencer_if #(.CNT_W(16)) bus ();

  phase_sequencer #(
    .HLT_OP  (HLT),
    .WAIT_MAX(8),
    .CNT_W   (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the expected state after the following edge.
  task automatic cyc(input logic r_rst, input logic r_run, input logic r_step,
                     input logic [2:0] r_ns, input logic [2:0] r_op,
                     input logic r_rd, input logic r_rdy,
                     input logic e_adv, input logic [2:0] e_ps,
                     input logic e_done, input logic e_halt, input logic e_err);
    rec_t r;
    ret_t t;
    @(negedge clk);
    rst         = r_rst;
    bus.run     = r_run;
    bus.step    = r_step;
    bus.nstate  = r_ns;
    bus.op      = r_op;
    bus.rd      = r_rd;
    bus.wr      = wr_drv;
    bus.mem_rdy = r_rdy;
    if (r_rst) begin
      exp_cnt = 16'd0;
    end else if (e_done) begin
      exp_cnt = exp_cnt + 16'd1;
      t.cnt  = exp_cnt;
      t.halt = e_halt;
      ret_q.push_back(t);
    end
    r.adv  = e_adv;
    r.ps   = e_ps;
    r.done = e_done;
    r.halt = e_halt;
    r.err  = e_err;
    r.cnt  = exp_cnt;
    rec_q.push_back(r);
  endtask

  initial begin : monitor
    rec_t r;
    ret_t t;
    logic adv_s;
    forever begin
      @(negedge clk);
      #4;
      adv_s = bus.advance;
      @(posedge clk);
      #1;
      if (rec_q.size() > 0) begin
        r = rec_q.pop_front();
        chk("advance",    32'(adv_s),          32'(r.adv));
        chk("pstate",     32'(bus.pstate),     32'(r.ps));
        chk("insn_done",  32'(bus.insn_done),  32'(r.done));
        chk("halted",     32'(bus.halted),     32'(r.halt));
        chk("bus_err",    32'(bus.bus_err),    32'(r.err));
        chk("insn_count", 32'(bus.insn_count), 32'(r.cnt));
      end
      if (bus.insn_done === 1'b1) begin
        if (ret_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_unexpected: got insn_done=1 expected no retirement at %0t", $time);
        end else begin
          t = ret_q.pop_front();
          chk("retire_count",  32'(bus.insn_count), 32'(t.cnt));
          chk("retire_halted", 32'(bus.halted),     32'(t.halt));
          $display("retire: count=%0d halted=%0b at %0t", bus.insn_count, bus.halted, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    checks      = 0;
    errors      = 0;
    exp_cnt     = 16'd0;
    wr_drv      = 1'b0;
    rst         = 1'b1;
    bus.run     = 1'b0;
    bus.step    = 1'b0;
    bus.nstate  = 3'd0;
    bus.op      = OPN;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.mem_rdy = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state
    cyc(1, 0, 0, 3'd0, OPN, 0, 1,  0, 3'd0, 0, 0, 0);

    // 1: free-run through a 4-phase instruction
    cyc(0, 1, 0, 3'd2, OPN, 0, 1,  0, 3'd0, 0, 0, 0);
    cyc(0, 1, 0, 3'd2, OPN, 0, 1,  1, 3'd2, 0, 0, 0);
    cyc(0, 1, 0, 3'd3, OPN, 0, 1,  1, 3'd3, 0, 0, 0);
    cyc(0, 1, 0, 3'd4, OPN, 0, 1,  1, 3'd4, 0, 0, 0);
    cyc(0, 0, 0, 3'd0, OPN, 0, 1,  1, 3'd0, 1, 0, 0);
    cyc(0, 0, 0, 3'd2, OPN, 0, 1,  0, 3'd0, 0, 0, 0);

    // 2: single step; run high at the boundary still returns to IDLE
    cyc(0, 0, 1, 3'd2, OPN, 0, 1,  0, 3'd0, 0, 0, 0);
    cyc(0, 0, 0, 3'd2, OPN, 0, 1,  1, 3'd2, 0, 0, 0);
    cyc(0, 0, 1, 3'd3, OPN, 0, 1,  1, 3'd3, 0, 0, 0);
    cyc(0, 0, 0, 3'd4, OPN, 0, 1,  1, 3'd4, 0, 0, 0);
    cyc(0, 1, 0, 3'd0, OPN, 0, 1,  1, 3'd0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 3'd3, OPN, 0, 1,  0, 3'd0, 0, 0, 0);
    end

    // 3: run wins over step; 3-cycle read stall, then 7-cycle write stall
    cyc(0, 1, 1, 3'd2, OPN, 0, 1,  0, 3'd0, 0, 0, 0);
    cyc(0, 1, 0, 3'd2, OPN, 1, 1,  1, 3'd2, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 3'd3, OPN, 1, 0,  0, 3'd2, 0, 0, 0);
    end
    cyc(0, 1, 0, 3'd3, OPN, 1, 1,  1, 3'd3, 0, 0, 0);
    wr_drv = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 0, 3'd0, OPN, 0, 0,  0, 3'd3, 0, 0, 0);
    end
    cyc(0, 1, 0, 3'd0, OPN, 0, 1,  1, 3'd0, 1, 0, 0);
    wr_drv = 1'b0;

    // 4: stall for WAIT_MAX cycles traps to bus error until reset
    cyc(0, 1, 0, 3'd2, OPN, 0, 1,  1, 3'd2, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 0, 3'd3, OPN, 1, 0,  0, 3'd2, 0, 0, 0);
    end
    cyc(0, 1, 0, 3'd3, OPN, 1, 0,  0, 3'd2, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 3'd3, OPN, 1, 1,  0, 3'd2, 0, 0, 1);
    end
    cyc(1, 0, 0, 3'd0, OPN, 0, 1,  0, 3'd0, 0, 0, 0);

    // 5: halt opcode retires and freezes; run dropped at the same boundary
    cyc(0, 1, 0, 3'd2, HLT, 0, 1,  0, 3'd0, 0, 0, 0);
    cyc(0, 1, 0, 3'd2, HLT, 0, 1,  1, 3'd2, 0, 0, 0);
    cyc(0, 0, 0, 3'd0, HLT, 0, 1,  1, 3'd0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, logic'(i % 2), logic'((i + 1) % 2), 3'd3, OPN, 0, 1,  0, 3'd0, 0, 1, 0);
    end
    cyc(1, 0, 0, 3'd0, OPN, 0, 1,  0, 3'd0, 0, 0, 0);

    // 6: run dropped at phase 3 finishes the instruction; reset mid-instruction
    cyc(0, 1, 0, 3'd2, OPN, 0, 1,  0, 3'd0, 0, 0, 0);
    cyc(0, 1, 0, 3'd2, OPN, 0, 1,  1, 3'd2, 0, 0, 0);
    cyc(0, 1, 0, 3'd3, OPN, 0, 1,  1, 3'd3, 0, 0, 0);
    cyc(0, 0, 0, 3'd4, OPN, 0, 1,  1, 3'd4, 0, 0, 0);
    cyc(0, 0, 0, 3'd0, OPN, 0, 1,  1, 3'd0, 1, 0, 0);
    cyc(0, 0, 0, 3'd2, OPN, 0, 1,  0, 3'd0, 0, 0, 0);
    cyc(0, 1, 0, 3'd2, OPN, 0, 1,  0, 3'd0, 0, 0, 0);
    cyc(0, 1, 0, 3'd2, OPN, 0, 1,  1, 3'd2, 0, 0, 0);
    cyc(1, 1, 0, 3'd3, OPN, 1, 0,  0, 3'd0, 0, 0, 0);
    cyc(0, 1, 0, 3'd3, OPN, 0, 1,  0, 3'd0, 0, 0, 0);
    cyc(0, 0, 0, 3'd3, OPN, 0, 1,  1, 3'd3, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("records_drained", 32'(rec_q.size()), 32'd0);
    chk("retires_drained", 32'(ret_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
